tdm_demux4: RTL and testbench

- Receive-side counterpart of the 4:1 mux datapath.
- Takes one serial time-division-multiplexed lane that carries 4 slots per frame (slot 0 = a … slot 3 = d).
- Routes each slot to its own channel register. Outputs are double-buffered so all four channels update together at frame completion.
- Sits at the far end of a link whose transmitter drives the lane through the 4:1 mux with a free-running 2-bit select.

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_slot_counter.sv | 64 ++++++
 rtl/tdm_demux4.sv | 115 +++++++++++
 tb/tb_tdm_demux4.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared frame geometry for the TDM lane receiver.
// TDM_DEMUX_PARITY_EN stretches the frame to five slots (four data words plus one parity word).
package tdm_pkg;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NUM_SLOTS = 5;
`else
  localparam int NUM_SLOTS = 4;
`endif

  localparam int LAST_SLOT = NUM_SLOTS - 1;

  typedef logic [2:0] slot_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot tracking for the TDM receiver: lock acquisition, flywheel wrap and resync on early frame_sync.
// Frame length follows TDM_DEMUX_PARITY_EN through tdm_pkg.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_sync,
  output slot_t                slot,
  output logic                 locked,
  output logic [LAST_SLOT-1:0] capture,
  output logic                 frame_done,
  output logic                 sync_error
);

  slot_t slot_d, slot_q;
  logic  locked_d, locked_q;
  logic  sync_error_d, sync_error_q;

  always_comb begin
    slot_d       = slot_q;
    locked_d     = locked_q;
    sync_error_d = 1'b0;
    capture      = '0;
    frame_done   = 1'b0;
    if (enable) begin
      if (frame_sync) begin
        // A sync always restarts the frame here; it is only an error if a frame was in progress.
        capture[0]   = 1'b1;
        slot_d       = slot_t'(1);
        locked_d     = 1'b1;
        sync_error_d = locked_q && (slot_q != '0);
      end else if (locked_q) begin
        if (slot_q == slot_t'(LAST_SLOT)) begin
          frame_done = 1'b1;
          slot_d     = '0;
        end else begin
          slot_d = slot_q + slot_t'(1);
          for (int i = 0; i < LAST_SLOT; i++) begin
            if (slot_q == slot_t'(i)) capture[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      locked_q     <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      locked_q     <= locked_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign slot       = slot_q;
  assign locked     = locked_q;
  assign sync_error = sync_error_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM lane receiver: slot words are shadowed, then all channels update together at frame end.
// Define TDM_DEMUX_PARITY_EN for a fifth even-parity slot and the parity_error output.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_sync,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [2:0]       slot,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_error
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic             parity_error
`endif
);

  logic [LAST_SLOT-1:0] capture;
  logic                 frame_done;
  slot_t                slot_w;

  logic [WIDTH-1:0] shadow_d [LAST_SLOT];
  logic [WIDTH-1:0] shadow_q [LAST_SLOT];
  logic [WIDTH-1:0] out_a_d, out_a_q;
  logic [WIDTH-1:0] out_b_d, out_b_q;
  logic [WIDTH-1:0] out_c_d, out_c_q;
  logic [WIDTH-1:0] out_d_d, out_d_q;
  logic             frame_valid_d, frame_valid_q;
`ifdef TDM_DEMUX_PARITY_EN
  logic             parity_error_d, parity_error_q;
  logic [WIDTH-1:0] parity_calc;
`endif

  tdm_slot_counter u_slot_counter (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .frame_sync (frame_sync),
    .slot       (slot_w),
    .locked     (locked),
    .capture    (capture),
    .frame_done (frame_done),
    .sync_error (sync_error)
  );

  always_comb begin
    for (int i = 0; i < LAST_SLOT; i++) begin
      shadow_d[i] = capture[i] ? in : shadow_q[i];
    end
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_c_d       = out_c_q;
    out_d_d       = out_d_q;
    frame_valid_d = frame_done;
`ifdef TDM_DEMUX_PARITY_EN
    parity_calc    = shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3];
    parity_error_d = frame_done && (in != parity_calc);
`endif
    if (frame_done) begin
      out_a_d = shadow_q[0];
      out_b_d = shadow_q[1];
      out_c_d = shadow_q[2];
`ifdef TDM_DEMUX_PARITY_EN
      out_d_d = shadow_q[3];
`else
      // Slot 3 bypasses the shadow so the last word reaches out_d on the same edge it arrives.
      out_d_d = in;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAST_SLOT; i++) shadow_q[i] <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_c_q       <= '0;
      out_d_q       <= '0;
      frame_valid_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < LAST_SLOT; i++) shadow_q[i] <= shadow_d[i];
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_c_q       <= out_c_d;
      out_d_q       <= out_d_d;
      frame_valid_q <= frame_valid_d;
`ifdef TDM_DEMUX_PARITY_EN
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_c       = out_c_q;
  assign out_d       = out_d_q;
  assign slot        = slot_w;
  assign frame_valid = frame_valid_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a word-list frame model feeds expected frames to a negedge monitor.
// Honours TDM_DEMUX_PARITY_EN for the five-slot build.
module tb_tdm_demux4;

  localparam int W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  typedef struct {
    logic [W-1:0] a, b, c, d;
    bit           perr;
  } frame_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] in_word = '0;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic [2:0]   slot;
  logic         locked, frame_valid, sync_error;
`ifdef TDM_DEMUX_PARITY_EN
  logic         parity_error;
`endif

  int total = 0;
  int bad = 0;

  frame_t       frame_q[$];
  bit           sync_q[$];
  logic [W-1:0] words[$];
  bit           m_locked = 0;
  int           exp_slot = 0;
  bit           exp_locked = 0;
  bit           mon_on = 0;
  frame_t       held = '{a: '0, b: '0, c: '0, d: '0, perr: 0};

  tdm_demux4 #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .frame_sync  (frame_sync),
    .in          (in_word),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .slot        (slot),
    .locked      (locked),
    .frame_valid (frame_valid),
    .sync_error  (sync_error)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is simply the list of words collected since the last sync or wrap.
  task automatic model_step(input bit en, input bit fs, input logic [W-1:0] word);
    frame_t       f;
    logic [W-1:0] par;
    if (!en) return;
    if (fs) begin
      if (m_locked && words.size() != 0) sync_q.push_back(1'b1);
      words.delete();
      words.push_back(word);
      m_locked = 1;
    end else if (m_locked) begin
      words.push_back(word);
      if (words.size() == FRAME_LEN) begin
        f.a = words[0]; f.b = words[1]; f.c = words[2]; f.d = words[3];
        par = words[0] ^ words[1] ^ words[2] ^ words[3];
        f.perr = (FRAME_LEN == 5) ? (words[FRAME_LEN-1] != par) : 1'b0;
        frame_q.push_back(f);
        words.delete();
      end
    end
    exp_slot   = words.size();
    exp_locked = m_locked;
  endtask

  task automatic applyStimulus(input bit en, input bit fs, input logic [W-1:0] word);
    enable     = en;
    frame_sync = fs;
    in_word    = word;
    @(posedge clock);
    model_step(en, fs, word);
    #1;
  endtask

  task automatic send_frame(input bit sync, input logic [W-1:0] w0, w1, w2, w3);
    logic [W-1:0] par;
    par = w0 ^ w1 ^ w2 ^ w3;
    applyStimulus(1, sync, w0);
    applyStimulus(1, 0, w1);
    applyStimulus(1, 0, w2);
    applyStimulus(1, 0, w3);
    if (FRAME_LEN == 5) applyStimulus(1, 0, par);
  endtask

  // Monitor: pops an expected frame or sync error whenever one is due, and holds outputs to the last popped frame otherwise.
  always @(negedge clock) begin
    frame_t e;
    bit     exp_fv, exp_se, exp_pe;
    if (reset) begin
      held = '{a: '0, b: '0, c: '0, d: '0, perr: 0};
    end else if (mon_on) begin
      exp_fv = (frame_q.size() != 0);
      exp_pe = 0;
      if (exp_fv) begin
        e = frame_q.pop_front();
        held = e;
        exp_pe = e.perr;
      end
      exp_se = (sync_q.size() != 0);
      if (exp_se) void'(sync_q.pop_front());
      checkOutput("frame_valid", 32'(frame_valid), 32'(exp_fv));
      checkOutput("sync_error", 32'(sync_error), 32'(exp_se));
      checkOutput("pulse_exclusive", 32'(frame_valid & sync_error), 32'd0);
      checkOutput("out_a", 32'(out_a), 32'(held.a));
      checkOutput("out_b", 32'(out_b), 32'(held.b));
      checkOutput("out_c", 32'(out_c), 32'(held.c));
      checkOutput("out_d", 32'(out_d), 32'(held.d));
      checkOutput("slot", 32'(slot), 32'(exp_slot));
      checkOutput("locked", 32'(locked), 32'(exp_locked));
`ifdef TDM_DEMUX_PARITY_EN
      checkOutput("parity_error", 32'(parity_error), 32'(exp_pe));
`else
      if (exp_pe) checkOutput("parity_model", 32'(exp_pe), 32'd0);
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_out_a"}, 32'(out_a), 32'd0);
    checkOutput({tag, "_out_b"}, 32'(out_b), 32'd0);
    checkOutput({tag, "_out_c"}, 32'(out_c), 32'd0);
    checkOutput({tag, "_out_d"}, 32'(out_d), 32'd0);
    checkOutput({tag, "_slot"}, 32'(slot), 32'd0);
    checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
    checkOutput({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    checkOutput({tag, "_sync_error"}, 32'(sync_error), 32'd0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_on = 1;

    // Words before any sync are discarded.
    repeat (6) applyStimulus(1, 0, 4'h1);

    // First locked frame.
    send_frame(1, 4'h1, 4'h0, 4'h1, 4'h1);
    applyStimulus(0, 0, 4'h0);

    // Flywheel: second frame carries no sync.
    send_frame(1, 4'h1, 4'h2, 4'h3, 4'h4);
    send_frame(0, 4'h5, 4'h6, 4'h7, 4'h8);

    // Early sync at slot 2 restarts the frame.
    applyStimulus(1, 1, 4'hA);
    applyStimulus(1, 0, 4'hB);
    send_frame(1, 4'hC, 4'hD, 4'hE, 4'hF);

    // enable low mid-frame with frame_sync asserted must be ignored.
    applyStimulus(1, 1, 4'h9);
    applyStimulus(1, 0, 4'h3);
    repeat (3) applyStimulus(0, 1, 4'h6);
    applyStimulus(1, 0, 4'h5);
    applyStimulus(1, 0, 4'h2);
    if (FRAME_LEN == 5) applyStimulus(1, 0, 4'h9 ^ 4'h3 ^ 4'h5 ^ 4'h2);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(1, 4'h1, 4'h1, 4'h0, 4'h0);
    applyStimulus(1, 1, 4'h1);
    applyStimulus(1, 0, 4'h1);
    applyStimulus(1, 0, 4'h0);
    applyStimulus(1, 0, 4'h0);
    applyStimulus(1, 0, 4'h1);
`endif

    // Asynchronous reset in the middle of a frame.
    applyStimulus(1, 1, 4'h7);
    applyStimulus(1, 0, 4'h8);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    frame_q.delete();
    sync_q.delete();
    words.delete();
    m_locked   = 0;
    exp_slot   = 0;
    exp_locked = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) applyStimulus(1, 0, 4'hF);

    // Randomised traffic: mostly enabled, occasional syncs.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 9) == 0, W'($urandom));
    end

    repeat (2) applyStimulus(0, 0, 4'h0);
    checkOutput("frame_q_drained", frame_q.size(), 32'd0);
    checkOutput("sync_q_drained", sync_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
